// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// bus widths and the {pc, instr} prefetch queue entry.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // no request outstanding
      ST_WAIT = 2'd1,  // request outstanding, data will be kept
      ST_DROP = 2'd2   // request outstanding, data will be discarded
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Word-addressed sequential successor, wrapping modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch unit's external handshakes: instruction memory bus,
// branch redirect input and the valid/ready stream to decode.
interface instruction_fetch_unit_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;

   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;

   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;

   // Fetch unit side.
   modport master (
      output imem_req, imem_addr,
      input  imem_ack, imem_data,
      input  redirect, redirect_pc,
      output if_valid, if_instr, if_pc,
      input  if_ready
   );

   // Environment side: memory, branch logic and decode.
   modport slave (
      input  imem_req, imem_addr,
      output imem_ack, imem_data,
      output redirect, redirect_pc,
      input  if_valid, if_instr, if_pc,
      output if_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries. Pointers carry one extra MSB so that
// full and empty are told apart without a separate occupancy register.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  fetch_entry_t           i_push_entry,
   input  logic                   i_pop,
   input  logic                   i_flush,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty,
   output logic                   o_full,
   output fetch_entry_t           o_head
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;

   // NOTE: the storage is reset so the head outputs read zero straight out of
   // reset; the array is small enough that this costs little.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_push && !i_flush) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
      end
   end

   // Flush wins over a simultaneous push or pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline fetch front end: owns the fetch PC, keeps one instruction-memory
// request outstanding at a time and feeds decode from a prefetch queue.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clock,
   input  logic                      reset_n,
   instruction_fetch_unit_if.master  bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e      r_state;
   fetch_state_e      w_state_next;
   logic [ADDR_W-1:0] r_req_addr;
   logic [ADDR_W-1:0] w_req_addr_next;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] w_fetch_pc_next;
   logic [ADDR_W-1:0] r_drop_pc;
   logic [ADDR_W-1:0] w_drop_pc_next;

   logic              w_push;
   logic              w_pop;
   logic              w_flush;
   logic              w_empty;
   logic              w_full;
   logic [CW-1:0]     w_count;
   logic [CW:0]       w_count_after;
   logic              w_room_after;
   fetch_entry_t      w_push_entry;
   fetch_entry_t      w_head;

   assign w_pop         = !w_empty && bus.if_ready;
   assign w_count_after = {1'b0, w_count} + (CW+1)'(1) - (CW+1)'(w_pop);
   assign w_room_after  = (w_count_after < (CW+1)'(DEPTH));
   assign w_push_entry  = '{pc: r_req_addr, instr: bus.imem_data};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_req_addr <= RESET_PC;
         r_fetch_pc <= RESET_PC;
         r_drop_pc  <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_req_addr <= w_req_addr_next;
         r_fetch_pc <= w_fetch_pc_next;
         r_drop_pc  <= w_drop_pc_next;
      end
   end

   // NOTE: every next-state value is defaulted to its current value first so
   // no path through the case statement leaves a latch behind.
   always_comb begin
      w_state_next    = r_state;
      w_req_addr_next = r_req_addr;
      w_fetch_pc_next = r_fetch_pc;
      w_drop_pc_next  = r_drop_pc;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.redirect) begin
               w_state_next    = ST_WAIT;
               w_req_addr_next = bus.redirect_pc;
            end else if (!w_full) begin
               w_state_next    = ST_WAIT;
               w_req_addr_next = r_fetch_pc;
            end
         end
         ST_WAIT: begin
            if (bus.redirect) begin
               // An unacknowledged request cannot be withdrawn, so its data is
               // dropped when it arrives and the target is fetched afterwards.
               if (bus.imem_ack) begin
                  w_req_addr_next = bus.redirect_pc;
               end else begin
                  w_drop_pc_next = bus.redirect_pc;
                  w_state_next   = ST_DROP;
               end
            end else if (bus.imem_ack) begin
               w_fetch_pc_next = next_pc(r_req_addr);
               if (w_room_after) begin
                  w_req_addr_next = next_pc(r_req_addr);
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         ST_DROP: begin
            if (bus.redirect) begin
               w_drop_pc_next = bus.redirect_pc;
            end
            if (bus.imem_ack) begin
               w_state_next    = ST_WAIT;
               w_req_addr_next = bus.redirect ? bus.redirect_pc : r_drop_pc;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // A redirect always empties the queue; data is kept only in WAIT.
   always_comb begin
      w_flush      = bus.redirect;
      w_push       = (r_state == ST_WAIT) && bus.imem_ack && !bus.redirect;
      bus.imem_req = (r_state != ST_IDLE);
   end

   assign bus.imem_addr = r_req_addr;
   assign bus.if_valid  = !w_empty;
   assign bus.if_instr  = w_head.instr;
   assign bus.if_pc     = w_head.pc;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_flush      (w_flush),
      .o_count      (w_count),
      .o_empty      (w_empty),
      .o_full       (w_full),
      .o_head       (w_head)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario bench for instruction_fetch_unit: directed fetch/stall/redirect
// cases plus a randomized run checked against an instruction-stream model.
module tb_instruction_fetch_unit;

   localparam int          DEPTH   = 4;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFE;

   logic clock = 1'b0;
   logic reset_n;
   logic reset_w_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   instruction_fetch_unit_if bus ();
   instruction_fetch_unit_if bus_w ();

   instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   instruction_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_w (
      .clock   (clock),
      .reset_n (reset_w_n),
      .bus     (bus_w)
   );

   always #5 clock = ~clock;

   // Instruction memory contents as a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic idle_inputs();
      bus.imem_ack    = 1'b0;
      bus.imem_data   = '0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.if_ready    = 1'b0;
   endtask

   // Leaves the DUT one cycle after reset release: first request visible.
   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clock);
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
      n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
      n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.if_valid); end
      n_checks++; if (bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.if_instr); end
      n_checks++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", bus.if_pc); end
      reset_n = 1'b1;
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req_early: got %b want 0", bus.imem_req); end
      @(negedge clock);
      n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
      n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_addr: got %h want 0", bus.imem_addr); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] k32;
      do_reset();
      bus.if_ready = 1'b1;
      bus.imem_ack = 1'b1;
      for (int k = 0; k < 12; k++) begin
         k32 = 32'(k);
         bus.imem_data = mem_word(bus.imem_addr);
         n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, k32}) begin n_fail++; $display("FAIL zw_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, k32); end
         if (k == 0) begin
            n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL zw_valid0: got %b want 0", bus.if_valid); end
         end else begin
            n_checks++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, k32 - 32'd1, mem_word(k32 - 32'd1)}) begin
               n_fail++; $display("FAIL zw_head[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, bus.if_valid, bus.if_pc, bus.if_instr, k32 - 32'd1, mem_word(k32 - 32'd1));
            end
         end
         @(negedge clock);
      end
      idle_inputs();
   endtask

   task automatic test_stall();
      int          pushes;
      int          accepted;
      logic [31:0] exp_pc;
      do_reset();
      bus.imem_ack = 1'b1;
      pushes = 0;
      for (int k = 0; k < 8; k++) begin
         bus.imem_data = mem_word(bus.imem_addr);
         if (bus.imem_req) pushes++;
         @(negedge clock);
      end
      n_checks++; if (pushes != DEPTH) begin n_fail++; $display("FAIL stall_pushes: got %0d want %0d", pushes, DEPTH); end
      n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_low: got %b want 0", bus.imem_req); end
      n_checks++; if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h want v=1 pc=0", bus.if_valid, bus.if_pc); end
      bus.if_ready = 1'b1;
      exp_pc   = 32'h0;
      accepted = 0;
      for (int k = 0; k < 40 && accepted < 8; k++) begin
         bus.imem_data = mem_word(bus.imem_addr);
         if (bus.if_valid) begin
            n_checks++; if ({bus.if_pc, bus.if_instr} !== {exp_pc, mem_word(exp_pc)}) begin n_fail++; $display("FAIL stall_drain: got pc=%h instr=%h want pc=%h instr=%h", bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd1;
            accepted++;
         end
         @(negedge clock);
      end
      n_checks++; if (accepted != 8) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 8", accepted); end
      idle_inputs();
   endtask

   task automatic test_redirect_wait();
      do_reset();
      bus.if_ready = 1'b1;
      @(negedge clock);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      @(negedge clock);
      bus.redirect = 1'b0;
      n_checks++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL rw_hold: got req=%b addr=%h v=%b want req=1 addr=0 v=0", bus.imem_req, bus.imem_addr, bus.if_valid); end
      @(negedge clock);
      bus.imem_ack  = 1'b1;
      bus.imem_data = mem_word(bus.imem_addr);
      @(negedge clock);
      bus.imem_ack = 1'b0;
      n_checks++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h100, 1'b0}) begin n_fail++; $display("FAIL rw_new_addr: got req=%b addr=%h v=%b want req=1 addr=100 v=0", bus.imem_req, bus.imem_addr, bus.if_valid); end
      repeat (2) begin
         @(negedge clock);
         n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rw_no_leak: got v=%b pc=%h want v=0", bus.if_valid, bus.if_pc); end
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = mem_word(bus.imem_addr);
      @(negedge clock);
      bus.imem_ack = 1'b0;
      n_checks++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h100, mem_word(32'h100)}) begin n_fail++; $display("FAIL rw_first: got v=%b pc=%h instr=%h want v=1 pc=100", bus.if_valid, bus.if_pc, bus.if_instr); end
      idle_inputs();
   endtask

   task automatic test_redirect_coincident();
      do_reset();
      bus.if_ready = 1'b1;
      bus.imem_ack = 1'b1;
      repeat (3) begin
         bus.imem_data = mem_word(bus.imem_addr);
         @(negedge clock);
      end
      n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL rc_pre_valid: got %b want 1", bus.if_valid); end
      bus.imem_data   = mem_word(bus.imem_addr);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h40;
      @(negedge clock);
      bus.redirect = 1'b0;
      n_checks++; if ({bus.if_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h40}) begin n_fail++; $display("FAIL rc_flush: got v=%b req=%b addr=%h want v=0 req=1 addr=40", bus.if_valid, bus.imem_req, bus.imem_addr); end
      bus.imem_data = mem_word(bus.imem_addr);
      @(negedge clock);
      n_checks++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h40, mem_word(32'h40)}) begin n_fail++; $display("FAIL rc_first: got v=%b pc=%h instr=%h want v=1 pc=40", bus.if_valid, bus.if_pc, bus.if_instr); end
      idle_inputs();
   endtask

   task automatic test_drop_double_redirect();
      do_reset();
      bus.if_ready = 1'b1;
      @(negedge clock);
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h10;
      @(negedge clock);
      bus.redirect_pc = 32'h20;
      @(negedge clock);
      bus.redirect = 1'b0;
      n_checks++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL dd_hold: got req=%b addr=%h v=%b want req=1 addr=0 v=0", bus.imem_req, bus.imem_addr, bus.if_valid); end
      bus.imem_ack  = 1'b1;
      bus.imem_data = mem_word(bus.imem_addr);
      @(negedge clock);
      n_checks++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h20, 1'b0}) begin n_fail++; $display("FAIL dd_resume: got req=%b addr=%h v=%b want req=1 addr=20 v=0", bus.imem_req, bus.imem_addr, bus.if_valid); end
      bus.imem_data = mem_word(bus.imem_addr);
      @(negedge clock);
      n_checks++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h20, mem_word(32'h20)}) begin n_fail++; $display("FAIL dd_first: got v=%b pc=%h instr=%h want v=1 pc=20", bus.if_valid, bus.if_pc, bus.if_instr); end
      idle_inputs();
   endtask

   task automatic test_wrap_and_async_reset();
      int          got;
      logic [31:0] exp_pc;
      bus_w.if_ready = 1'b1;
      bus_w.imem_ack = 1'b1;
      reset_w_n = 1'b1;
      @(negedge clock);
      got = 0;
      for (int k = 0; k < 20 && got < 4; k++) begin
         bus_w.imem_data = mem_word(bus_w.imem_addr);
         if (bus_w.if_valid) begin
            exp_pc = WRAP_PC + 32'(got);
            n_checks++; if ({bus_w.if_pc, bus_w.if_instr} !== {exp_pc, mem_word(exp_pc)}) begin n_fail++; $display("FAIL wrap_pc[%0d]: got pc=%h instr=%h want pc=%h", got, bus_w.if_pc, bus_w.if_instr, exp_pc); end
            got++;
         end
         @(negedge clock);
      end
      n_checks++; if (got != 4) begin n_fail++; $display("FAIL wrap_count: got %0d want 4", got); end
      bus_w.imem_ack = 1'b0;
      @(negedge clock);
      n_checks++; if (bus_w.imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_mid_wait: got req=%b want 1", bus_w.imem_req); end
      #2 reset_w_n = 1'b0;
      #1;
      n_checks++; if ({bus_w.imem_req, bus_w.imem_addr, bus_w.if_valid} !== {1'b0, WRAP_PC, 1'b0}) begin n_fail++; $display("FAIL async_rst_req: got req=%b addr=%h v=%b want req=0 addr=%h v=0", bus_w.imem_req, bus_w.imem_addr, bus_w.if_valid, WRAP_PC); end
      n_checks++; if ({bus_w.if_instr, bus_w.if_pc} !== 64'h0) begin n_fail++; $display("FAIL async_rst_head: got instr=%h pc=%h want 0 0", bus_w.if_instr, bus_w.if_pc); end
      @(negedge clock);
      bus_w.if_ready = 1'b0;
   endtask

   // Random ack/ready/redirect traffic. The model is the architectural
   // instruction stream: consecutive PCs, restarting at each redirect target.
   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] prev_addr;
      logic [31:0] prev_target;
      logic        prev_hold;
      logic        prev_redir;
      int          accepted;
      do_reset();
      exp_pc     = 32'h0;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
      prev_addr  = '0;
      prev_target = '0;
      accepted   = 0;
      for (int k = 0; k < 3000; k++) begin
         if (prev_hold) begin
            n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_addr}) begin n_fail++; $display("FAIL rnd_hold[%0d]: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, prev_addr); end
         end
         if (prev_redir) begin
            n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush[%0d]: got v=%b want 0", k, bus.if_valid); end
            if (!prev_hold) begin
               n_checks++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, prev_target}) begin n_fail++; $display("FAIL rnd_target[%0d]: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req, bus.imem_addr, prev_target); end
            end
         end
         bus.if_ready  = ($urandom_range(0, 9) < 7);
         bus.imem_ack  = ($urandom_range(0, 1) == 1);
         bus.imem_data = bus.imem_ack ? mem_word(bus.imem_addr) : $urandom;
         bus.redirect  = ($urandom_range(0, 19) == 0);
         bus.redirect_pc = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         if (!bus.redirect && bus.if_valid && bus.if_ready) begin
            n_checks++; if ({bus.if_pc, bus.if_instr} !== {exp_pc, mem_word(exp_pc)}) begin n_fail++; $display("FAIL rnd_stream[%0d]: got pc=%h instr=%h want pc=%h instr=%h", k, bus.if_pc, bus.if_instr, exp_pc, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd1;
            accepted++;
         end
         if (bus.redirect) exp_pc = bus.redirect_pc;
         prev_hold   = bus.imem_req && !bus.imem_ack;
         prev_addr   = bus.imem_addr;
         prev_redir  = bus.redirect;
         prev_target = bus.redirect_pc;
         @(negedge clock);
      end
      idle_inputs();
      n_checks++; if (accepted < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d accepted want >= 200", accepted); end
   endtask

   initial begin
      reset_w_n         = 1'b0;
      bus_w.imem_ack    = 1'b0;
      bus_w.imem_data   = '0;
      bus_w.redirect    = 1'b0;
      bus_w.redirect_pc = '0;
      bus_w.if_ready    = 1'b0;
      test_reset();
      test_zero_wait();
      test_stall();
      test_redirect_wait();
      test_redirect_coincident();
      test_drop_double_redirect();
      test_wrap_and_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
